// File: rtl/dmem_ctrl_if.sv
// Processor-side DMEM request/response bus for dmem_ctrl.
// Master is the MEM stage; slave is the controller.
interface dmem_ctrl_if;
    logic        req_valid;
    logic        ready;
    logic [0:31] addr_to_mem;
    logic        write_enable_to_mem;
    logic        byte_to_mem;
    logic        half_word_to_mem;
    logic        sign_extend_to_mem;
    logic [0:31] data_to_mem;
    logic [0:31] data_from_mem;
    logic        resp_valid;
    logic        misalign_err;

    modport master (
        output req_valid, addr_to_mem, write_enable_to_mem, byte_to_mem,
               half_word_to_mem, sign_extend_to_mem, data_to_mem,
        input  ready, data_from_mem, resp_valid, misalign_err
    );

    modport slave (
        input  req_valid, addr_to_mem, write_enable_to_mem, byte_to_mem,
               half_word_to_mem, sign_extend_to_mem, data_to_mem,
        output ready, data_from_mem, resp_valid, misalign_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte/half/word loads and stores onto a synchronous-read SRAM,
// sub-word stores via read-modify-write. Optional macro: DMEM_MISALIGN_CHECK_EN.
module dmem_ctrl #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    dmem_ctrl_if.slave        bus,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_re,
    output logic              sram_we,
    output logic [0:31]       sram_wdata,
    input  logic [0:31]       sram_rdata
);

    typedef enum logic [1:0] {StIdle, StRead, StResp} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] waddr_q;
    logic [0:1]        off_q;
    logic              we_q, byte_q, half_q, sext_q;
    logic [16:31]      wdata_q;
    logic [0:31]       data_q;

    logic        accept, misalign, is_half, is_word;
    logic [0:7]  ld_byte;
    logic [0:15] ld_half;
    logic [0:31] load_val, merged;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^bus.addr_to_mem[0:29-ADDR_W];

    // Byte wins when both size flags are set.
    assign is_half = bus.half_word_to_mem && !bus.byte_to_mem;
    assign is_word = !bus.half_word_to_mem && !bus.byte_to_mem;
    assign accept  = reset && (state_q == StIdle) && bus.req_valid;

`ifdef DMEM_MISALIGN_CHECK_EN
    logic err_q;
    assign misalign = (is_half && bus.addr_to_mem[31]) ||
                      (is_word && (bus.addr_to_mem[30:31] != 2'b00));
    always_ff @(posedge clock) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= misalign;
        end
    end
    assign bus.misalign_err = err_q && (state_q == StResp);
`else
    assign misalign         = 1'b0;
    assign bus.misalign_err = 1'b0;
`endif

    assign bus.ready         = (state_q == StIdle);
    assign bus.resp_valid    = (state_q == StResp);
    assign bus.data_from_mem = data_q;

    // Lane extraction and merge, big-endian: offset 0 is bits [0:7].
    always_comb begin
        ld_byte = sram_rdata[0:7];
        merged  = sram_rdata;
        unique case (off_q)
            2'd0: begin ld_byte = sram_rdata[0:7];   merged[0:7]   = wdata_q[24:31]; end
            2'd1: begin ld_byte = sram_rdata[8:15];  merged[8:15]  = wdata_q[24:31]; end
            2'd2: begin ld_byte = sram_rdata[16:23]; merged[16:23] = wdata_q[24:31]; end
            2'd3: begin ld_byte = sram_rdata[24:31]; merged[24:31] = wdata_q[24:31]; end
        endcase
        ld_half = off_q[0] ? sram_rdata[16:31] : sram_rdata[0:15];
        if (byte_q) begin
            load_val = {{24{sext_q && ld_byte[0]}}, ld_byte};
        end else if (half_q) begin
            load_val = {{16{sext_q && ld_half[0]}}, ld_half};
            merged   = sram_rdata;
            if (off_q[0]) merged[16:31] = wdata_q;
            else          merged[0:15]  = wdata_q;
        end else begin
            load_val = sram_rdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        sram_re    = 1'b0;
        sram_we    = 1'b0;
        sram_wdata = '0;
        sram_addr  = waddr_q;
        unique case (state_q)
            StIdle: begin
                sram_addr = bus.addr_to_mem[30-ADDR_W:29];
                if (accept) begin
                    if (misalign) begin
                        state_d = StResp;
                    end else if (bus.write_enable_to_mem && is_word) begin
                        sram_we    = 1'b1;
                        sram_wdata = bus.data_to_mem;
                        state_d    = StResp;
                    end else begin
                        sram_re = 1'b1;
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                // Reset in this cycle must suppress the RMW write-back.
                if (reset && we_q) begin
                    sram_we    = 1'b1;
                    sram_wdata = merged;
                end
                state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            waddr_q <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            half_q  <= 1'b0;
            sext_q  <= 1'b0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                waddr_q <= bus.addr_to_mem[30-ADDR_W:29];
                off_q   <= bus.addr_to_mem[30:31];
                we_q    <= bus.write_enable_to_mem;
                byte_q  <= bus.byte_to_mem;
                half_q  <= is_half;
                sext_q  <= bus.sign_extend_to_mem;
                wdata_q <= bus.data_to_mem[16:31];
                if (misalign && !bus.write_enable_to_mem) data_q <= '0;
            end
            if (state_q == StRead && !we_q) data_q <= load_val;
        end
    end

endmodule
